// File: rtl/seg_pkg.sv
// Shared constants and nibble helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 3;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  function automatic logic [NIB_W-1:0] nib_sel(input logic [DATA_W-1:0] data,
                                               input logic [IDX_W-1:0]  idx);
    logic [DATA_W-1:0] sh;
    sh = data >> {idx, 2'b00};
    return sh[NIB_W-1:0];
  endfunction

  // True when nibble idx and every nibble above it are zero.
  function automatic logic upper_zero(input logic [DATA_W-1:0] data,
                                      input logic [IDX_W-1:0]  idx);
    logic [DATA_W-1:0] sh;
    sh = data >> {idx, 2'b00};
    return (sh == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running prescaler: counts 0..CLK_DIV-1 and flags the last count with tick.
module seg_prescaler #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_W'(CLK_DIV - 1));
  assign cnt  = cnt_r;

  // Prescaler count register, wrapping on tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a double-buffered,
// tear-free display value loaded over a valid/ready handshake.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 2000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] data_in,
  input  logic        data_vld,
  output logic        data_rdy,
  input  logic        lz_en,
  output logic [3:0]  num,
  output logic [7:0]  led_en
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

  logic [CNT_W-1:0]  cnt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              tick_s;
  logic              frame_s;
  logic              accept_s;
  logic              blank_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [DATA_W-1:0] shadow_r;
  logic [DATA_W-1:0] disp_r;
  logic [DATA_W-1:0] disp_nxt_s;
  logic              pending_r;
  logic              pending_nxt_s;
  logic [7:0]        led_nxt_s;
  logic [7:0]        led_en_r;
  logic [NIB_W-1:0]  num_r;

  seg_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick_s),
    .cnt    (cnt_s)
  );

  // Next-state decode; outputs are derived from next-state so they line up with the live slot.
  always_comb begin
    frame_s   = tick_s && (idx_r == IDX_W'(NUM_DIGITS - 1));
    accept_s  = data_vld && !pending_r;
    cnt_nxt_s = tick_s ? {CNT_W{1'b0}} : (cnt_s + CNT_W'(1));
    idx_nxt_s = tick_s ? (idx_r + IDX_W'(1)) : idx_r;

    if (frame_s && pending_r) begin
      disp_nxt_s = shadow_r;
    end else begin
      disp_nxt_s = disp_r;
    end

    if (accept_s) begin
      pending_nxt_s = 1'b1;
    end else if (frame_s) begin
      pending_nxt_s = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end

    blank_s = lz_en && (idx_nxt_s != {IDX_W{1'b0}}) && upper_zero(disp_nxt_s, idx_nxt_s);

    if ((cnt_nxt_s < DEAD_C) || blank_s) begin
      led_nxt_s = ANODE_OFF;
    end else begin
      led_nxt_s = ~(8'b0000_0001 << idx_nxt_s);
    end
  end

  // Digit index, buffers, handshake state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_r     <= {IDX_W{1'b0}};
      shadow_r  <= {DATA_W{1'b0}};
      disp_r    <= {DATA_W{1'b0}};
      pending_r <= 1'b0;
      led_en_r  <= ANODE_OFF;
      num_r     <= {NIB_W{1'b0}};
    end else begin
      idx_r     <= idx_nxt_s;
      disp_r    <= disp_nxt_s;
      pending_r <= pending_nxt_s;
      if (accept_s) begin
        shadow_r <= data_in;
      end else begin
        shadow_r <= shadow_r;
      end
      led_en_r  <= led_nxt_s;
      num_r     <= nib_sel(disp_nxt_s, idx_nxt_s);
    end
  end

  assign data_rdy = ~pending_r;
  assign led_en   = led_en_r;
  assign num      = num_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a per-cycle expected-output scoreboard.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 1;
  localparam int FRAME   = 8 * CLK_DIV;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] num;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        data_vld = 1'b0;
  logic        lz_en = 1'b0;
  logic        data_rdy;
  logic [3:0]  num;
  logic [7:0]  led_en;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string phase = "init";

  int          m_cnt;
  int          m_idx;
  logic [31:0] m_disp;
  logic [31:0] m_shadow;
  logic        m_pending;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (data_in),
    .data_vld (data_vld),
    .data_rdy (data_rdy),
    .lz_en    (lz_en),
    .num      (num),
    .led_en   (led_en)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_led(logic [31:0] d, logic lz, int cnt, int idx);
    logic [31:0] up;
    up = d >> (4 * idx);
    if (cnt < DEAD) return 8'hFF;
    if (lz && (idx != 0) && (up == 32'h0)) return 8'hFF;
    return ~(8'h01 << idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%h expected=%h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_disp = 32'h0; m_shadow = 32'h0; m_pending = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the next cycle's outputs, then compare.
  task automatic step(input logic vld, input logic [31:0] d, input logic lz);
    exp_t e;
    logic tick;
    logic frame;
    data_vld = vld;
    data_in  = d;
    lz_en    = lz;
    tick  = (m_cnt == CLK_DIV - 1);
    frame = tick && (m_idx == 7);
    if (frame && m_pending) begin
      m_disp = m_shadow;
      m_pending = 1'b0;
    end else if (vld && !m_pending) begin
      m_shadow = d;
      m_pending = 1'b1;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) m_idx = (m_idx + 1) % 8;
    e.led = exp_led(m_disp, lz, m_cnt, m_idx);
    e.num = m_disp[4*m_idx +: 4];
    e.rdy = !m_pending;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("led_en", 32'(led_en), 32'(e.led));
    check("num", 32'(num), 32'(e.num));
    check("data_rdy", 32'(data_rdy), 32'(e.rdy));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    phase = "reset";
    check("led_en", 32'(led_en), 32'hFF);
    check("num", 32'(num), 32'h0);
    check("data_rdy", 32'(data_rdy), 32'h1);
    resetn = 1'b1;
    #1;
    check("led_en_rel", 32'(led_en), 32'hFF);

    phase = "scan_zero";
    for (int c = 0; c < FRAME; c++) step(1'b0, 32'h0, 1'b0);

    phase = "load";
    for (int c = 0; c < FRAME; c++) step(c == 0, 32'h1234_5678, 1'b0);

    phase = "tear_free";
    for (int c = 0; c < FRAME; c++) begin
      step(c == 12, 32'hAAAA_AAAA, 1'b0);
      if (c == 0) begin
        check("d0_led", 32'(led_en), 32'hFE);
        check("d0_num", 32'(num), 32'h8);
      end
      if (c == 29) begin
        check("d7_led", 32'(led_en), 32'h7F);
        check("d7_num", 32'(num), 32'h1);
      end
    end

    phase = "backpressure_a";
    for (int c = 0; c < FRAME; c++) begin
      step(c >= 2, (c == 2) ? 32'hF : ((c < 20) ? 32'h1 : 32'h2), 1'b0);
      if (c == 0) check("all_a_num", 32'(num), 32'hA);
    end

    phase = "backpressure_b";
    for (int c = 0; c < FRAME; c++) step(c != FRAME - 1, (c == 0) ? 32'h2 : 32'h3, 1'b0);

    phase = "backpressure_c";
    for (int c = 0; c < FRAME; c++) begin
      step(c == 4, 32'h0000_0A05, c == FRAME - 1);
      if (c == 0) check("held_num", 32'(num), 32'h2);
    end

    phase = "blank_a05";
    for (int c = 0; c < FRAME; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (c == 9) begin
        check("d2_led", 32'(led_en), 32'hFB);
        check("d2_num", 32'(num), 32'hA);
      end
      if (c == 13) check("d3_blank", 32'(led_en), 32'hFF);
    end

    phase = "blank_load0";
    for (int c = 0; c < FRAME; c++) step(c == 0, 32'h0, 1'b1);

    phase = "blank_zero";
    for (int c = 0; c < FRAME; c++) begin
      step(1'b0, 32'h0, c < 15);
      if (c == 1) check("z0_led", 32'(led_en), 32'hFE);
      if (c == 5) check("z1_blank", 32'(led_en), 32'hFF);
      if (c == 17) check("z4_restored", 32'(led_en), 32'hEF);
    end

    phase = "mid_reset";
    for (int c = 0; c < 17; c++) step(c == 0, 32'hDEAD_BEEF, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_led", 32'(led_en), 32'hFF);
    check("rst_rdy", 32'(data_rdy), 32'h1);
    check("rst_num", 32'(num), 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rel_led", 32'(led_en), 32'hFF);

    phase = "after_reset";
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1'b0, 32'h0, 1'b0);
      if (c == 0) check("restart_led", 32'(led_en), 32'hFE);
      if (c == FRAME) check("discard_num", 32'(num), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode seven-segment bank on the board. It is fed 32-bit debug values (PC, ALU result, register contents) from the CPU through a valid/ready handshake and stores them in double-buffered, tear-free registers. It cycles through the digits, driving the active-low anode enables and the 4-bit hex nibble `num`. `num` feeds the seven-segment decoder directly downstream.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- DEAD, 2000, blanking cycles at the start of each slot (anti-ghosting); legal range 0 ≤ DEAD < CLK_DIV.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- data_in  in  32  value to display; nibble k is data_in[4k+3:4k] and maps to digit k (digit 0 is rightmost)
- data_vld  in  1  data_in valid
- data_rdy  out  1  shadow buffer free
- lz_en  in  1  leading-zero blanking enable
- num  out  4  hex nibble for the current digit, to the segment decoder
- led_en  out  8  anode enables, active low, one-hot-low or all 1

Behaviour:
- Reset (async assert, sync release) sets:
  - cnt=0, idx=0, shadow=0, disp=0, pending=0
  - outputs: led_en=8'hFF, num=0, data_rdy=1
- Prescaler cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
- Digit index idx advances by 1 on each tick. It wraps 7→0. A frame is 8 slots; frame length = 8*CLK_DIV cycles.
- Handshake:
  - data_rdy = ~pending (registered).
  - Transfer occurs when data_vld & data_rdy: shadow<=data_in, pending<=1, and data_rdy is low from the next cycle.
  - data_vld while data_rdy=0 is not accepted. Upstream must hold. No data is lost or overwritten.
- Frame boundary is defined as tick & idx==7.
  - At a frame boundary with pending=1: disp<=shadow, pending<=0. data_rdy is high the next cycle.
  - If data is accepted in the same cycle as a frame boundary with pending=0, it does not transfer in that cycle. It waits for the following boundary.
  - disp never changes mid-frame (tear-free).
- Outputs are registered and are functions of the current cycle's cnt/idx (computed from next-state):
  - num = disp nibble[idx], valid in every cycle including dead time.
  - led_en = 8'hFF if cnt < DEAD, or if digit idx is blanked.
  - Otherwise led_en = ~(8'b1 << idx).
- Leading-zero blanking: when lz_en=1, digit k (k≥1) is blanked if nibbles k..7 of disp are all zero. Digit 0 is never blanked. lz_en is sampled every cycle with no latching.
- DEAD=0 means no dead time: exactly one anode is active whenever the digit is not blanked.
- Reset asserted mid-frame forces all reset values immediately (asynchronously). Any pending shadow data is discarded.
- No combinational path from inputs to outputs.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS=8, NIB_W=4, DATA_W=32
  - ANODE_OFF=8'hFF
  - function nib_sel(data, idx)
- One natural sub-module: seg_prescaler (parameter CLK_DIV; ports clk, resetn; output tick). It is reusable for other board-level timers.
- Handshake, buffers, idx, blanking and output registers live in the top.

Test Plan (CLK_DIV=4, DEAD=1 unless noted):
1. Reset: while resetn=0 → led_en=FF, num=0, data_rdy=1. After release with disp=0 and lz_en=0 → each slot has 1 cycle led_en=FF then 3 cycles of FE, FD, …, 7F in order, with num=0.
2. Load 0x12345678 (one-cycle vld) → data_rdy=0 next cycle. From the next frame: digit0 num=8 led_en=FE … digit7 num=1 led_en=7F. data_rdy=1 the cycle after the boundary.
3. Tear-free: accept 0xAAAAAAAA while idx=3 of a frame displaying 0x12345678 → idx 4..7 still show 4,3,2,1; the next frame shows A on every digit.
4. Backpressure: hold vld with 0x1 then change data_in to 0x2 while data_rdy=0 → the accepted value is the one present in the cycle data_rdy=1. Check exactly one transfer per rdy window.
5. Blanking: lz_en=1 with disp=0x00000A05 → digits 0..2 active (5, 0, A), led_en bits 3..7 stay 1. With disp=0 → only digit 0 active, num=0. Toggling lz_en=0 restores all digits immediately.
6. Reset mid-frame at idx=4 with pending=1 → led_en=FF in the same cycle, data_rdy=1. After release, the scan restarts at idx=0 showing disp=0 and the pending value is discarded.
